// File: rtl/div.sv
// div: multi-cycle radix-2 restoring 32-bit divider for DIV/DIVU, result {HI=remainder, LO=quotient}
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t      state;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  cnt;
  logic        s1, s2;
  logic [31:0] abs1, abs2, q, r;
  logic [32:0] t;
  always_comb begin
    abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    t    = {1'b0, dividend[63:32]} - {1'b0, divisor};
    q    = (s1 ^ s2) ? -dividend[31:0] : dividend[31:0];
    r    = s1 ? -dividend[64:33] : dividend[64:33];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: if (start_i && !annul_i) begin
          s1 <= signed_div_i & opdata1_i[31];
          s2 <= signed_div_i & opdata2_i[31];
          if (opdata2_i == '0) state <= BYZERO;
          else begin
            state    <= ON;
            cnt      <= '0;
            dividend <= {32'b0, abs1, 1'b0};
            divisor  <= abs2;
          end
        end
        BYZERO: if (annul_i) state <= FREE;
        else begin
          state    <= END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: if (annul_i) begin
          state <= FREE;
          cnt   <= '0;
        end else if (cnt != 6'd32) begin
          // a borrow means the trial subtraction failed: keep the partial remainder, quotient bit 0
          dividend <= t[32] ? {dividend[63:0], 1'b0} : {t[31:0], dividend[31:0], 1'b1};
          cnt      <= cnt + 6'd1;
        end else begin
          state    <= END;
          cnt      <= '0;
          result_o <= {r, q};
          ready_o  <= 1'b1;
        end
        END: if (!start_i) begin
          state    <= FREE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: directed scoreboard bench for the multi-cycle divider
module tb_div;
  logic        clk = 1'b0;
  logic        rst, signed_div_i, start_i, annul_i, ready_o, seen;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic [63:0] exp_q[$];
  int          compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic watch(input int cycles, output logic hit);
    hit = 1'b0;
    repeat (cycles) begin
      step();
      hit |= ready_o;
    end
  endtask

  // called at a negedge; leaves start_i high with the result held
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input bit perturb);
    int n;
    logic [63:0] e;
    exp_q.push_back(exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (perturb && n == 5) begin
        opdata1_i = ~a;
        opdata2_i = 32'd1;
        signed_div_i = ~sgn;
      end
    end while (!ready_o && n < 100);
    check({tag, " latency"}, 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check({tag, " result"}, result_o, e);
  endtask

  task automatic release_chk(input string tag);
    start_i = 1'b0;
    step();
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) step();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    step();

    run_op("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b0);
    repeat (5) begin
      step();
      check("u100/7 hold ready", 64'(ready_o), 64'd1);
      check("u100/7 hold result", result_o, {32'd2, 32'd14});
    end
    release_chk("u100/7");

    run_op("s-7/2", 1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 1'b0);
    release_chk("s-7/2");
    run_op("s7/-2", 1'b1, 32'd7, -32'sd2, {32'h00000001, 32'hFFFFFFFD}, 34, 1'b0);
    release_chk("s7/-2");
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 1'b0);
    release_chk("s_ovf");
    run_op("uFFFF/1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, 1'b0);
    release_chk("uFFFF/1");
    run_op("u8000/FFFF", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 34, 1'b0);
    release_chk("u8000/FFFF");
    run_op("s5/0", 1'b1, 32'd5, 32'd0, 64'd0, 2, 1'b0);
    release_chk("s5/0");
    run_op("u5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b0);
    release_chk("u5/0");

    // start masked by annul in FREE; a zero divisor would otherwise finish in 2 edges
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
    watch(4, seen);
    start_i = 1'b0; annul_i = 1'b0;
    check("annul masks start", 64'(seen), 64'd0);
    step();

    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    watch(10, seen);
    annul_i = 1'b1; start_i = 1'b0;
    step();
    annul_i = 1'b0;
    watch(40, seen);
    check("annul in ON", 64'(seen), 64'd0);

    run_op("u9/3 perturbed", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 1'b1);
    release_chk("u9/3 perturbed");

    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    watch(20, seen);
    rst = 1'b1; start_i = 1'b0;
    step();
    rst = 1'b0;
    check("mid reset ready", 64'(ready_o), 64'd0);
    check("mid reset result", result_o, 64'd0);
    run_op("u50/5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34, 1'b0);
    release_chk("u50/5");

    run_op("u9/2", 1'b0, 32'd9, 32'd2, {32'd1, 32'd4}, 34, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0; start_i = 1'b0;
    check("end reset ready", 64'(ready_o), 64'd0);
    check("end reset result", result_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
